mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch port and the data-access port of the multi-cycle CPU, replacing separate instruction and data memories. It issues one access at a time, round-robins simultaneous requests, tracks the fixed memory read latency, and routes read data and completion back to the owning requester. It sits between the CPU's `inst_addr`/`inst` and `dm_*` interfaces and the unified memory.

## Interface

**Parameters**
- `MEM_LAT`, default 1: cycles from the issue cycle (`mem_en`=1) to valid `mem_rdata`. Must be ≥1; values 1..15 are supported.

**Ports**

Clock, reset and the owning requester:
- `clk`  in  1  system clock. Single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.

Instruction-fetch requester:
- `if_req`  in  1  fetch request. Held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  one-cycle pulse in the issue cycle.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` is valid in this cycle.
- `if_rdata`  out  32  fetched word.

Data requester:
- `dm_req`  in  1  data request. Held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  32  byte address.
- `dm_wdata`  in  32  store data.
- `dm_gnt`  out  1  one-cycle pulse in the issue cycle.
- `dm_rvalid`  out  1  one-cycle completion pulse, for both loads and stores.
- `dm_rdata`  out  32  load data. 0 on store completion.

Memory port:
- `mem_en`  out  1  access strobe, one cycle per access.
- `mem_we`  out  1  write enable. Never 1 while `mem_en`=0.
- `mem_addr`  out  32  byte address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid `MEM_LAT` cycles after issue.

Debug:
- `watch_owner`  out  2  current owner: 0 = none, 1 = IF, 2 = DM.

## Operation
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding, latency counter running.
- Arbitration at an issue opportunity:
  - Only `if_req`: grant IF. Only `dm_req`: grant DM.
  - Both: grant the port not granted last (`last_owner`).
  - `last_owner` resets to IF, so the first tie goes to DM.
- Issue cycle:
  - Assert the granted `*_gnt` and `mem_en`.
  - Drive `mem_addr`, `mem_wdata` and `mem_we` from the granted port. IF issues always have `mem_we`=0.
  - Latch the owner, set `cnt = MEM_LAT-1`, go to WAIT.
- WAIT:
  - While `cnt`≠0, decrement. No grants; memory outputs are 0.
  - When `cnt`=0, this is the completion cycle: pulse the owner's `*_rvalid` and route `mem_rdata` to its `*_rdata` (DM store: `dm_rdata`=0).
  - The completion cycle is also an issue opportunity. If a request is pending, issue per the arbitration rules and stay in WAIT. Otherwise go to IDLE.
- Non-owner `*_rdata` reads 0. `*_rvalid` is never asserted for a port without an outstanding access.
- Addresses are passed through unmodified. Alignment is the requester's responsibility.
- At most one outstanding access at any time.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `cnt`=0, `last_owner`=IF, `watch_owner`=0.
- Issue latency: request seen in IDLE is granted the same cycle, combinationally from `*_req`.
- Read latency: `*_rvalid` arrives exactly `MEM_LAT` cycles after `*_gnt`.
- Throughput: one access per `MEM_LAT` cycles with back-to-back requests. With `MEM_LAT`=1, one access per cycle.
- Fairness: with both requests held continuously, grants alternate DM, IF, DM, IF, …
- A request dropped before grant is legal; nothing is issued for it.
- A request that rises during WAIT is considered at the completion cycle.
- Reset mid-access:
  - The outstanding access is abandoned. No `rvalid` is ever produced for it.
  - All outputs are 0 from the cycle after the reset edge.
- `watch_owner` equals the latched owner in WAIT, 0 in IDLE.

## Structure
- Shared defines header (`define/arb.v`) holds:
  - `OWNER_NONE`=0, `OWNER_IF`=1, `OWNER_DM`=2.
  - State encodings `ARB_IDLE` and `ARB_WAIT`.
- One natural sub-module, `arb_lat_counter`: load, decrement and zero-detect for the `MEM_LAT` countdown.
- Arbitration and muxing stay in the top module.

## Test plan
- **Reset values, `MEM_LAT`=2.** Hold `rst` for 2 cycles with `if_req`=1 → no `if_gnt` during reset; first `if_gnt` is in the cycle after `rst` falls; `if_rvalid` 2 cycles later with `if_rdata`=`mem[if_addr]`.
- **Simultaneous requests, `MEM_LAT`=1.** Hold `if_req`=`dm_req`=1 from reset for 4 accesses → grant order DM, IF, DM, IF; one `mem_en` per cycle; each `rvalid` one cycle after its `gnt`.
- **Store then load.** `dm_we`=1, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF; then load from 0x40 → `mem_we`=1 only in the store issue cycle; `dm_rvalid` with `dm_rdata`=0 for the store; load returns 0xDEADBEEF.
- **Latency hold-off, `MEM_LAT`=3.** Raise `if_req` one cycle after a DM grant → `if_gnt` waits until the DM `rvalid` cycle; `mem_en` is 0 during the 2 wait cycles in between.
- **Reset mid-access, `MEM_LAT`=3.** Assert `rst` one cycle after `dm_gnt` → no `dm_rvalid` is ever produced; all outputs are 0 the next cycle; the next tie is granted to DM.
- **Dropped request.** Pulse `if_req` for one cycle during WAIT with `dm_req`=0 → no `if_gnt`; FSM returns to IDLE after completion; `watch_owner`=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - owner codes, FSM states and the round-robin pick for the shared memory port
package mem_port_arbiter_pkg;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_IF   = 2'd1;
  localparam logic [1:0] OWNER_DM   = 2'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // Round-robin pick: a lone request wins outright, a tie goes to the port not granted last.
  function automatic logic [1:0] pick_owner(input logic if_req, input logic dm_req,
                                            input logic [1:0] last_owner);
    logic [1:0] pick;
    pick = OWNER_NONE;
    if (if_req && dm_req) begin
      pick = (last_owner == OWNER_IF) ? OWNER_DM : OWNER_IF;
    end else if (dm_req) begin
      pick = OWNER_DM;
    end else if (if_req) begin
      pick = OWNER_IF;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// rtl/arb_lat_counter.sv - countdown of the fixed memory read latency with zero detect
module arb_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

  logic [3:0] cnt;

  // Load on issue, then count down to zero and hold; zero marks the completion cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  watch_owner
);

  arb_state_t state, state_next;
  logic [1:0] owner, owner_next;
  logic [1:0] last_owner, last_owner_next;
  logic       owner_we, owner_we_next;
  logic       cnt_load, cnt_zero;
  logic       completing, issue_ok;
  logic [1:0] pick;

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .zero (cnt_zero)
  );

  // State, latched owner/store flag and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWNER_NONE;
      owner_we   <= 1'b0;
      last_owner <= OWNER_IF;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      owner_we   <= owner_we_next;
      last_owner <= last_owner_next;
    end
  end

  // Completion routing, arbitration and memory-port muxing; everything is held at 0 while rst is high
  // so a request present during reset is never granted and an abandoned access never completes.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    owner_we_next   = owner_we;
    last_owner_next = last_owner;
    cnt_load        = 1'b0;
    if_gnt          = 1'b0;
    if_rvalid       = 1'b0;
    if_rdata        = 32'd0;
    dm_gnt          = 1'b0;
    dm_rvalid       = 1'b0;
    dm_rdata        = 32'd0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = 32'd0;
    mem_wdata       = 32'd0;
    watch_owner     = OWNER_NONE;

    completing = (state == ARB_WAIT) && cnt_zero;
    issue_ok   = (state == ARB_IDLE) || completing;
    pick       = pick_owner(if_req, dm_req, last_owner);

    if (!rst) begin
      if (state == ARB_WAIT) begin
        watch_owner = owner;
      end

      if (completing) begin
        if (owner == OWNER_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end else if (owner == OWNER_DM) begin
          dm_rvalid = 1'b1;
          dm_rdata  = owner_we ? 32'd0 : mem_rdata;
        end
      end

      if (issue_ok) begin
        case (pick)
          OWNER_DM: begin
            dm_gnt          = 1'b1;
            mem_en          = 1'b1;
            mem_we          = dm_we;
            mem_addr        = dm_addr;
            mem_wdata       = dm_wdata;
            owner_next      = OWNER_DM;
            owner_we_next   = dm_we;
            last_owner_next = OWNER_DM;
            cnt_load        = 1'b1;
            state_next      = ARB_WAIT;
          end
          OWNER_IF: begin
            if_gnt          = 1'b1;
            mem_en          = 1'b1;
            mem_addr        = if_addr;
            owner_next      = OWNER_IF;
            owner_we_next   = 1'b0;
            last_owner_next = OWNER_IF;
            cnt_load        = 1'b1;
            state_next      = ARB_WAIT;
          end
          default: begin
            if (completing) begin
              state_next = ARB_IDLE;
              owner_next = OWNER_NONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int NCYC = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  watch_owner;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .watch_owner(watch_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] dev_mem [64];
  logic [31:0] pipe [LAT];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  assign mem_rdata = pipe[LAT-1];

  // Memory device: read data appears LAT cycles after the issue edge; idle slots carry noise.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    if (mem_en && !mem_we) pipe[0] = dev_mem[mem_addr[7:2]];
    else pipe[0] = $urandom;
    if (mem_en && mem_we) dev_mem[mem_addr[7:2]] = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Monitor: every cycle, compare completion outputs against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("if_rvalid", 32'(if_rvalid), 32'(!e.is_dm));
        check("dm_rvalid", 32'(dm_rvalid), 32'(e.is_dm));
        check("if_rdata", if_rdata, e.is_dm ? 32'd0 : e.data);
        check("dm_rdata", dm_rdata, e.is_dm ? e.data : 32'd0);
      end else begin
        check("if_rvalid_idle", 32'(if_rvalid), 32'd0);
        check("dm_rvalid_idle", 32'(dm_rvalid), 32'd0);
        check("if_rdata_idle", if_rdata, 32'd0);
        check("dm_rdata_idle", dm_rdata, 32'd0);
      end
    end
  end

  // Stimulus plus reference model: the memory is a free resource from the completion cycle of the
  // previous access onward; ties go to whichever port was not granted most recently.
  initial begin
    bit          if_pend = 0, dm_pend = 0, dm_w = 0;
    logic [31:0] if_a = 0, dm_a = 0, dm_d = 0;
    bit          last_dm = 0, out_valid = 0, out_dm = 0;
    int          out_due = 0;
    bit          g_if = 0, g_dm = 0, free;
    logic [1:0]  exp_watch;
    exp_t        e;

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (g_if) if_pend = 0;
      if (g_dm) dm_pend = 0;

      if (c < 30) begin
        if (!if_pend) begin if_pend = 1; if_a = rand_addr(); end
        if (!dm_pend) begin dm_pend = 1; dm_w = ~dm_w; dm_a = 32'h40; dm_d = 32'hDEADBEEF; end
      end else if (c < NCYC - 10) begin
        if (if_pend && $urandom_range(0, 15) == 0) if_pend = 0;
        else if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_a = rand_addr(); end
        if (dm_pend && $urandom_range(0, 15) == 0) dm_pend = 0;
        else if (!dm_pend && $urandom_range(0, 2) == 0) begin
          dm_pend = 1; dm_w = 1'($urandom_range(0, 1)); dm_a = rand_addr(); dm_d = $urandom;
        end
      end else begin
        if_pend = 0;
        dm_pend = 0;
      end

      rst      = (c < 2) || (c == 70) || (c > 40 && c < NCYC - 10 && $urandom_range(0, 59) == 0);
      if_req   = if_pend;
      if_addr  = if_a;
      dm_req   = dm_pend;
      dm_we    = dm_w;
      dm_addr  = dm_a;
      dm_wdata = dm_d;
      #1;

      g_if = 0;
      g_dm = 0;
      if (rst) begin
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_watch", 32'(watch_owner), 32'd0);
        q.delete();
        out_valid = 0;
        last_dm   = 0;
      end else begin
        exp_watch = (out_valid && c <= out_due) ? (out_dm ? 2'd2 : 2'd1) : 2'd0;
        check("watch_owner", 32'(watch_owner), 32'(exp_watch));
        free = !out_valid || c >= out_due;
        if (free && if_pend && dm_pend) begin
          g_dm = !last_dm;
          g_if = last_dm;
        end else if (free) begin
          g_if = if_pend;
          g_dm = dm_pend;
        end
        check("if_gnt", 32'(if_gnt), 32'(g_if));
        check("dm_gnt", 32'(dm_gnt), 32'(g_dm));
        check("mem_en", 32'(mem_en), 32'(g_if | g_dm));
        if (g_dm) begin
          check("mem_we_dm", 32'(mem_we), 32'(dm_w));
          check("mem_addr_dm", mem_addr, dm_a);
          check("mem_wdata_dm", mem_wdata, dm_d);
          e.is_dm = 1;
          e.data  = dm_w ? 32'd0 : ref_mem[dm_a[7:2]];
          e.due   = c + LAT;
          if (dm_w) ref_mem[dm_a[7:2]] = dm_d;
          q.push_back(e);
          last_dm = 1; out_valid = 1; out_dm = 1; out_due = c + LAT;
        end else if (g_if) begin
          check("mem_we_if", 32'(mem_we), 32'd0);
          check("mem_addr_if", mem_addr, if_a);
          e.is_dm = 0;
          e.data  = ref_mem[if_a[7:2]];
          e.due   = c + LAT;
          q.push_back(e);
          last_dm = 0; out_valid = 1; out_dm = 0; out_due = c + LAT;
        end else begin
          check("mem_we_idle", 32'(mem_we), 32'd0);
        end
      end
    end

    @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
